fifo_wr_arbiter: RTL

// - Shares the single write port of one fifo instance between NREQ requesters (Lease Cache test traffic sources).
// - Round-robin arbitration with a credit counter, so writes never exceed fifo depth.
// - Full-flag latency is not relied on.
// - Sits between the traffic generators and fifo din_i/wr_en_i; the fifo consumer reports each read via fifo_rd_done_i.

---
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-limited arbiter sharing one fifo write port among NREQ requesters.
// Optional multi-beat grants are enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int width     = 8,
    parameter int depth     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*width-1:0]    data_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [width-1:0]         fifo_din_o,
    output logic                     fifo_wr_en_o,
    input  logic                     fifo_rd_done_i,
    output logic [$clog2(depth):0]   count_o,
    output logic                     busy_o
);

    localparam int PW  = $clog2(NREQ);
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(depth) + 1;
    localparam int BW  = $clog2(MAX_BURST) + 1;

    localparam logic [PW:0]    NREQ_C  = PW1'(NREQ);
    localparam logic [PW-1:0]  LAST_C  = PW'(NREQ - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(depth);
    localparam logic [BW-1:0]  MAX_C   = BW'(MAX_BURST);
    localparam logic [NREQ-1:0] ONE_C  = NREQ'(1);

`ifdef FIFO_ARB_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_idx;
    logic [BW-1:0]    r_beats;
    logic [CW-1:0]    r_count;
    logic [NREQ-1:0]  r_ack;
    logic [width-1:0] r_din;
    logic             r_wr_en;
    logic             r_busy;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW:0]      w_sum;
    logic [PW-1:0]    w_ptr_next;
    logic [CW-1:0]    w_count_next;
    logic             w_burst_go;

    // Winner search: descending scan so the lowest offset from r_ptr overrides the rest.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum   = {1'b0, r_ptr} + PW1'(i);
            w_sum   = (w_sum >= NREQ_C) ? (w_sum - NREQ_C) : w_sum;
            w_found = w_found | req_i[w_sum[PW-1:0]];
            w_win   = req_i[w_sum[PW-1:0]] ? w_sum[PW-1:0] : w_win;
        end
        w_ptr_next = (w_win == LAST_C) ? '0 : (w_win + PW'(1));
    end

    // Credit tracking: a write and a read in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({r_wr_en, fifo_rd_done_i})
            2'b10:   w_count_next = (r_count < DEPTH_C) ? (r_count + CW'(1)) : r_count;
            2'b01:   w_count_next = (r_count != '0) ? (r_count - CW'(1)) : r_count;
            default: w_count_next = r_count;
        endcase
        w_burst_go = BURST_EN & req_i[r_idx] & (r_beats < MAX_C) & (w_count_next < DEPTH_C);
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_beats <= '0;
            r_count <= '0;
            r_ack   <= '0;
            r_din   <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_found && (r_count < DEPTH_C)) begin
                        r_state <= ST_GRANT;
                        r_ptr   <= w_ptr_next;
                        r_idx   <= w_win;
                        r_beats <= BW'(1);
                        r_ack   <= ONE_C << w_win;
                        r_din   <= data_i[w_win*width +: width];
                        r_wr_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ack   <= '0;
                        r_din   <= '0;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_burst_go) begin
                        r_beats <= r_beats + BW'(1);
                        r_din   <= data_i[r_idx*width +: width];
                    end else begin
                        r_state <= ST_IDLE;
                        r_ack   <= '0;
                        r_din   <= '0;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= '0;
                    r_din   <= '0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o        = r_ack;
    assign fifo_din_o   = r_din;
    assign fifo_wr_en_o = r_wr_en;
    assign count_o      = r_count;
    assign busy_o       = r_busy;

endmodule
